posicionamento_frota: RTL

// - Builds the 5x7 defence (position) matrix pos_a0..pos_e6 that the attack logic reads; it writes the matrix, the attack side only reads it.
// - Player enters column, row and orientation on the switches and confirms with botao.
// - Ships are placed one at a time with bounds and overlap checks.
// - When the fleet is complete the matrix freezes and pronto goes high, which starts the attack phase.

---
 rtl/posicionamento_frota.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/posicionamento_frota.sv
// Fleet placement: builds the 5x7 defence matrix one ship at a time with bounds/overlap checks.
// Optional macro NO_TOUCH_EN additionally rejects ships orthogonally adjacent to existing ones.
module posicionamento_frota #(
  parameter int LEN0       = 3,
  parameter int LEN1       = 2,
  parameter int LEN2       = 1,
  parameter int DEB_CYCLES = 250000,
  parameter int FB_CYCLES  = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ch0,
  input  logic       ch1,
  input  logic       ch2,
  input  logic       ch3,
  input  logic       ch4,
  input  logic       ch5,
  input  logic       ch6,
  input  logic       ch7,
  input  logic       botao,
  output logic       pos_a0, output logic pos_a1, output logic pos_a2, output logic pos_a3,
  output logic       pos_a4, output logic pos_a5, output logic pos_a6,
  output logic       pos_b0, output logic pos_b1, output logic pos_b2, output logic pos_b3,
  output logic       pos_b4, output logic pos_b5, output logic pos_b6,
  output logic       pos_c0, output logic pos_c1, output logic pos_c2, output logic pos_c3,
  output logic       pos_c4, output logic pos_c5, output logic pos_c6,
  output logic       pos_d0, output logic pos_d1, output logic pos_d2, output logic pos_d3,
  output logic       pos_d4, output logic pos_d5, output logic pos_d6,
  output logic       pos_e0, output logic pos_e1, output logic pos_e2, output logic pos_e3,
  output logic       pos_e4, output logic pos_e5, output logic pos_e6,
  output logic [1:0] navio,
  output logic       pronto,
  output logic       verde,
  output logic       vermelho
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int FB_W  = $clog2(FB_CYCLES + 1);

  typedef enum logic [2:0] {
    PLACE    = 3'd0,
    CHECK    = 3'd1,
    COMMIT   = 3'd2,
    REJECT   = 3'd3,
    FEEDBACK = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t             state;
  logic [34:0]        pos;
  logic               btn_p0, btn_p1;
  logic               filt, filt_d;
  logic [DEB_W-1:0]   deb_cnt;
  logic [FB_W-1:0]    fb_cnt;
  logic [2:0]         col_l, row_l, len_l;
  logic               ori_l;
  logic               press;
  logic [34:0]        mask;
  logic               ok;

  // Cell index is col*7 + row, so a0=0, a6=6, b0=7 ... e6=34.
  function automatic logic [34:0] footprint(input logic [2:0] c, input logic [2:0] r,
                                            input logic o, input logic [2:0] l);
    logic [34:0] m;
    m = '0;
    for (int ci = 0; ci < 5; ci++)
      for (int ri = 0; ri < 7; ri++)
        if (o ? (ci == int'(c) && ri >= int'(r) && ri < int'(r) + int'(l))
              : (ri == int'(r) && ci >= int'(c) && ci < int'(c) + int'(l)))
          m[ci*7+ri] = 1'b1;
    return m;
  endfunction

  // Widened to 4 bits so the far end of a ship cannot wrap back into range.
  function automatic logic fits(input logic [2:0] c, input logic [2:0] r,
                                input logic o, input logic [2:0] l);
    logic [3:0] ce, re;
    ce = {1'b0, c} + {1'b0, l} - 4'd1;
    re = {1'b0, r} + {1'b0, l} - 4'd1;
    return (c <= 3'd4) && (r <= 3'd6) && (o ? (re <= 4'd6) : (ce <= 4'd4));
  endfunction

  function automatic logic [34:0] neighbours(input logic [34:0] p);
    logic [34:0] n;
    n = '0;
    for (int ci = 0; ci < 5; ci++)
      for (int ri = 0; ri < 7; ri++)
        if (p[ci*7+ri]) begin
          if (ri > 0) n[ci*7+ri-1] = 1'b1;
          if (ri < 6) n[ci*7+ri+1] = 1'b1;
          if (ci > 0) n[ci*7+ri-7] = 1'b1;
          if (ci < 4) n[ci*7+ri+7] = 1'b1;
        end
    return n;
  endfunction

  function automatic logic [2:0] len_sel(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'(LEN0);
      2'd1:    return 3'(LEN1);
      default: return 3'(LEN2);
    endcase
  endfunction

  // ---- button conditioning: synchroniser, debounce, edge detect ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_p0  <= 1'b0;
      btn_p1  <= 1'b0;
      filt    <= 1'b0;
      filt_d  <= 1'b0;
      deb_cnt <= '0;
    end else begin
      btn_p0 <= botao;
      btn_p1 <= btn_p0;
      filt_d <= filt;
      if (btn_p1 == filt)
        deb_cnt <= '0;
      else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        filt    <= btn_p1;
        deb_cnt <= '0;
      end else
        deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign press = filt & ~filt_d;

  // ---- placement check on the latched request ----
  assign mask = footprint(col_l, row_l, ori_l, len_l);
`ifdef NO_TOUCH_EN
  assign ok = fits(col_l, row_l, ori_l, len_l) && ((mask & pos) == '0) &&
              ((mask & neighbours(pos)) == '0);
`else
  assign ok = fits(col_l, row_l, ori_l, len_l) && ((mask & pos) == '0);
`endif

  // ---- placement FSM ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= PLACE;
      pos      <= '0;
      navio    <= 2'd0;
      pronto   <= 1'b0;
      verde    <= 1'b0;
      vermelho <= 1'b0;
      fb_cnt   <= '0;
      col_l    <= 3'd0;
      row_l    <= 3'd0;
      ori_l    <= 1'b0;
      len_l    <= 3'd0;
    end else begin
      case (state)
        PLACE: begin
          if (press) begin
            if (ch7) begin
              pos    <= '0;
              navio  <= 2'd0;
              verde  <= 1'b1;
              fb_cnt <= '0;
              state  <= FEEDBACK;
            end else begin
              col_l <= {ch5, ch4, ch3};
              row_l <= {ch2, ch1, ch0};
              ori_l <= ch6;
              len_l <= len_sel(navio);
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          fb_cnt <= '0;
          if (ok) begin
            pos   <= pos | mask;
            navio <= navio + 2'd1;
            verde <= 1'b1;
            state <= COMMIT;
          end else begin
            vermelho <= 1'b1;
            state    <= REJECT;
          end
        end
        COMMIT: begin
          fb_cnt <= fb_cnt + 1'b1;
          if (navio == 2'd3) begin
            pronto <= 1'b1;
            state  <= DONE;
          end else
            state <= FEEDBACK;
        end
        REJECT: begin
          fb_cnt <= fb_cnt + 1'b1;
          state  <= FEEDBACK;
        end
        FEEDBACK: begin
          if (fb_cnt >= FB_W'(FB_CYCLES - 1)) begin
            verde    <= 1'b0;
            vermelho <= 1'b0;
            state    <= PLACE;
          end else
            fb_cnt <= fb_cnt + 1'b1;
        end
        DONE: begin
          pronto <= 1'b1;
          verde  <= 1'b1;
        end
        default: state <= PLACE;
      endcase
    end
  end

  assign pos_a0 = pos[0];  assign pos_a1 = pos[1];  assign pos_a2 = pos[2];
  assign pos_a3 = pos[3];  assign pos_a4 = pos[4];  assign pos_a5 = pos[5];
  assign pos_a6 = pos[6];
  assign pos_b0 = pos[7];  assign pos_b1 = pos[8];  assign pos_b2 = pos[9];
  assign pos_b3 = pos[10]; assign pos_b4 = pos[11]; assign pos_b5 = pos[12];
  assign pos_b6 = pos[13];
  assign pos_c0 = pos[14]; assign pos_c1 = pos[15]; assign pos_c2 = pos[16];
  assign pos_c3 = pos[17]; assign pos_c4 = pos[18]; assign pos_c5 = pos[19];
  assign pos_c6 = pos[20];
  assign pos_d0 = pos[21]; assign pos_d1 = pos[22]; assign pos_d2 = pos[23];
  assign pos_d3 = pos[24]; assign pos_d4 = pos[25]; assign pos_d5 = pos[26];
  assign pos_d6 = pos[27];
  assign pos_e0 = pos[28]; assign pos_e1 = pos[29]; assign pos_e2 = pos[30];
  assign pos_e3 = pos[31]; assign pos_e4 = pos[32]; assign pos_e5 = pos[33];
  assign pos_e6 = pos[34];

endmodule
